// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes, FSM
// states and a helper that classifies which operations move bits.
package usr_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_ROR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ASR  = 3'b101,
    MODE_LOAD = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // True for the operations that eject a bit (shifts and rotates); only
  // these are allowed to run as a multi-cycle burst and to update ser_out.
  function automatic logic is_shift_mode(input mode_e m);
    return (m inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR});
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// One step of the register operation: computes the next register value and
// the bit pushed out of the register. Purely combinational; shared by the
// single-step and burst paths so both always agree on the operation.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  input  logic             d_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] next_q,
  output logic             eject_bit
);

  // Next-value and ejected-bit selection for every operation code.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    next_q    = q;
    eject_bit = 1'b0;
    case (mode)
      MODE_HOLD: next_q = q;
      MODE_SHR: begin
        next_q    = {d_in, q[WIDTH-1:1]};
        eject_bit = q[0];
      end
      MODE_SHL: begin
        next_q    = {q[WIDTH-2:0], d_in};
        eject_bit = q[WIDTH-1];
      end
      MODE_ROR: begin
        next_q    = {q[0], q[WIDTH-1:1]};
        eject_bit = q[0];
      end
      MODE_ROL: begin
        next_q    = {q[WIDTH-2:0], q[WIDTH-1]};
        eject_bit = q[WIDTH-1];
      end
      MODE_ASR: begin
        next_q    = {q[WIDTH-1], q[WIDTH-1:1]};
        eject_bit = q[0];
      end
      MODE_LOAD: next_q = par_in;
      MODE_CLR:  next_q = '0;
      default:   next_q = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with a single-step path (en) and a burst path
// (start/shamt) that shifts one position per enabled cycle, reporting
// progress on busy and completion on a one-cycle done pulse.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW_W  = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  input  logic [SW_W-1:0]   shamt,
  input  logic              d_in,
  input  logic [WIDTH-1:0]  par_in,
  output logic [WIDTH-1:0]  d_out,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  state_e            state, state_n;
  mode_e             mode_q, mode_q_n;
  logic [SW_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]  q_n;
  logic              ser_n, busy_n, done_n;

  mode_e             mode_in;
  mode_e             op_mode;
  logic [WIDTH-1:0]  step_q;
  logic              step_eject;

  assign mode_in = mode_e'(mode);

  // While bursting, the latched mode drives the datapath; live mode is ignored.
  assign op_mode = (state == BUSY) ? mode_q : mode_in;

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .q         (d_out),
    .mode      (op_mode),
    .d_in      (d_in),
    .par_in    (par_in),
    .next_q    (step_q),
    .eject_bit (step_eject)
  );

  // Next-state, counter and output-register values.
  always_comb begin
    state_n  = state;
    mode_q_n = mode_q;
    cnt_n    = cnt;
    q_n      = d_out;
    ser_n    = ser_out;
    busy_n   = busy;
    done_n   = 1'b0;  // done is a pulse: it drops on every edge unless re-fired
    case (state)
      IDLE: begin
        if (start) begin
          if (is_shift_mode(mode_in) && (shamt != '0)) begin
            // Accept the burst; shifting begins on the following edge.
            mode_q_n = mode_in;
            cnt_n    = shamt;
            state_n  = BUSY;
            busy_n   = 1'b1;
          end else begin
            // Zero-length or non-shift request completes as a single op.
            q_n    = step_q;
            if (is_shift_mode(mode_in)) ser_n = step_eject;
            done_n = 1'b1;
          end
        end else if (en) begin
          q_n = step_q;
          if (is_shift_mode(mode_in)) ser_n = step_eject;
        end
      end
      BUSY: begin
        if (en) begin
          q_n   = step_q;
          ser_n = step_eject;  // only shift modes are ever latched
          cnt_n = cnt - SW_W'(1);
          if (cnt == SW_W'(1)) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset that aborts any burst.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      mode_q  <= MODE_HOLD;
      cnt     <= '0;
      d_out   <= '0;
      ser_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_q_n;
      cnt     <= cnt_n;
      d_out   <= q_n;
      ser_out <= ser_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised universal shift register that generalises the lab's 4-bit right-shift register. It has configurable width, eight operating modes (hold, logical left/right, rotate, arithmetic right, load, clear), a single-step path, and a burst path that shifts N positions over N cycles with a busy/done handshake. It drives board LEDs in the lab top levels and serves as a serialiser/deserialiser building block for later exercises.

## Interface
- WIDTH, 8: register width in bits. Legal values are 2 to 32.
- SW_W, $clog2(WIDTH+1): width of shamt. Derived; do not override.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; **synchronous, active-high**.
- en  in  1  step/advance enable.
- start  in  1  burst request, sampled in IDLE only.
- mode  in  3  operation select (codes under Operation).
- shamt  in  SW_W  burst shift count, 0 to WIDTH.
- d_in  in  1  serial input bit.
- par_in  in  WIDTH  parallel load data.
- d_out  out  WIDTH  register contents (registered).
- ser_out  out  1  bit ejected by the most recent shift or rotate (registered).
- busy  out  1  burst in progress (registered).
- done  out  1  one-cycle burst/op completion pulse (registered).

## Operation
- Mode codes:
  - 000 HOLD.
  - 001 SHR: d_in enters the MSB; d_out[0] is ejected.
  - 010 SHL: d_in enters the LSB; d_out[WIDTH-1] is ejected.
  - 011 ROR.
  - 100 ROL.
  - 101 ASR: MSB is replicated.
  - 110 LOAD: d_out <= par_in.
  - 111 CLR: d_out <= 0.
- ser_out updates only on a shift or rotate edge (modes 001-101). It holds otherwise, including on LOAD and CLR.
- FSM states are IDLE and BUSY.
- IDLE, priority order rst > start > en:
  - start=1 with a shift mode (001-101) and shamt>0: latch mode into mode_q, set cnt=shamt, go to BUSY, busy<=1. No shift on this edge.
  - start=1 with shamt=0, or with mode 000/110/111: apply mode once on this edge (000 does nothing), done<=1, stay in IDLE.
  - start=0 and en=1: apply mode once. done stays 0.
  - start=0 and en=0: hold.
- BUSY:
  - en=1: apply mode_q, cnt<=cnt-1.
  - When cnt==1 on that edge: go to IDLE, busy<=0, done<=1.
  - en=0: stall. Register, cnt and ser_out all hold.
  - start and mode are ignored.
  - d_in is sampled live on every shift edge.
- done is high for exactly one cycle and deasserts on the next edge unconditionally.

## Timing
- Reset: on a clock edge with rst=1, d_out=0, ser_out=0, busy=0, done=0, state=IDLE, cnt=0. This overrides any in-flight burst, and no done pulse is produced.
- Single step: d_out reflects the op one edge after en is sampled.
- Burst without stalls:
  - start sampled at edge E0.
  - busy is high from after E0 until after E(shamt).
  - Shifts occur at edges E1 through E(shamt).
  - done is high in the cycle after E(shamt), and d_out already holds the final value in that cycle.
- Burst with stalls: each en=0 cycle in BUSY extends busy and done by one cycle.
- shamt=WIDTH:
  - Rotates return the original value.
  - SHR/SHL with d_in=0 produce 0.
  - ASR produces all copies of the sign bit.
- shamt>WIDTH is illegal. The bench never drives it, and the RTL behaviour is undefined.
- A back-to-back burst is allowed: start may be asserted in the same cycle done is high. That cycle is in IDLE.

## Structure
- Package usr_pkg holds:
  - the mode_e enum (3-bit codes above);
  - the state_e enum (IDLE, BUSY);
  - localparam MODE_W=3.
- Sub-module usr_shift_step: purely combinational next-value function of (q, mode, d_in), returning next_q and eject_bit. It is shared by the step and burst paths.
- Top module: FSM, cnt register, output registers.

## Test plan
All scenarios use WIDTH=8.
- Reset: LOAD 0xA5, then rst=1 for one edge → d_out=0x00, ser_out=0, busy=0, done=0.
- Single step: LOAD 0xA5, then en=1, mode=SHR, d_in=1 → d_out=0xD2 and ser_out=1. Follow with SHL, d_in=0 → d_out=0xA4 and ser_out=1.
- Burst ROL: d_out=0x81, start with shamt=3 → busy high 3 cycles, then d_out=0x0C, ser_out=0, done high exactly 1 cycle.
- Burst ASR with stall: d_out=0x80, start with shamt=8, en=0 for 2 cycles mid-burst → busy high 10 cycles, final d_out=0xFF, ser_out=1.
- Abort and ignore: rst during the 2nd cycle of a shamt=5 burst → all outputs 0 on the next cycle and no done. start with mode=LOAD asserted while busy → ignored.
- Degenerate start: start with shamt=0 → done next cycle and d_out unchanged. Then start on the done cycle with ROR, shamt=8 on 0x3C → final d_out=0x3C.
